// File: rtl/collective_scheduler_if.sv
// collective_scheduler_if: host command channel and node broadcast bus
//   cmd_valid/cmd_op/cmd_size/cmd_ready : host command handshake
//   node_rvalid[x]                      : per-node ready pulses
//   node_cvalid/node_cdata[w]           : broadcast word to all nodes
interface collective_scheduler_if #(
   parameter int x = 4,
   parameter int w = 128
);
   logic          cmd_valid;
   logic [31:0]   cmd_op;
   logic [31:0]   cmd_size;
   logic          cmd_ready;
   logic [x-1:0]  node_rvalid;
   logic          node_cvalid;
   logic [w-1:0]  node_cdata;
   modport master (
      output cmd_valid, cmd_op, cmd_size, node_rvalid,
      input  cmd_ready, node_cvalid, node_cdata
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_size, node_rvalid,
      output cmd_ready, node_cvalid, node_cdata
   );
endinterface

// File: rtl/collective_scheduler.sv
// collective_scheduler: queues host commands and broadcasts op/size words once every node is ready
//   clock   : single clock, posedge
//   reset   : asynchronous active-low reset
//   bus     : command handshake and node broadcast bus (slave side)
//   busy    : FSM active or commands queued
//   issued  : wrapping count of broadcast commands
//   error   : sticky flag for duplicate node pulses and dropped illegal commands
module collective_scheduler #(
   parameter int x = 4,
   parameter int w = 128,
   parameter int d = 5,
   parameter int q = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   collective_scheduler_if.slave        bus,
   output logic                         busy,
   output logic [15:0]                  issued,
   output logic                         error
);
   typedef enum logic [1:0] {IDLE, SEND_OP, SEND_SIZE} state_t;
   localparam logic [31:0] blk = 32'(x * w / 8);
   localparam logic [63:0] max_size = 64'(blk) << d;
   state_t        state;
   logic [31:0]   op_mem   [2**q];
   logic [31:0]   size_mem [2**q];
   logic [q-1:0]  wr_ptr, rd_ptr;
   logic [q:0]    count;
   logic [x-1:0]  mask, mask_base;
   logic [31:0]   head_op, head_size;
   logic          legal, go, drop, push, pop, dup;
   assign head_op   = op_mem[rd_ptr];
   assign head_size = size_mem[rd_ptr];
   assign legal     = head_op < 32'd2 && head_size != 32'd0 && head_size % blk == 32'd0 &&
                      {32'd0, head_size} <= max_size;
   assign go        = state == IDLE && &mask && count != '0;
   assign drop      = go && !legal;
   assign pop       = drop || state == SEND_SIZE;
   // count only reaches 2^q when full, so its top bit is the full flag
   assign bus.cmd_ready = !count[q];
   assign push      = bus.cmd_valid && !count[q];
   // the mask clears at the end of SEND_SIZE; pulses in that cycle belong to the next barrier
   assign mask_base = state == SEND_SIZE ? '0 : mask;
   assign dup       = |(bus.node_rvalid & mask_base);
   assign busy      = state != IDLE || count != '0;
   always_ff @(posedge clock) begin
      if (push) begin
         op_mem[wr_ptr]   <= bus.cmd_op;
         size_mem[wr_ptr] <= bus.cmd_size;
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         mask            <= '0;
         issued          <= '0;
         error           <= 1'b0;
         bus.node_cvalid <= 1'b0;
         bus.node_cdata  <= '0;
      end else begin
         mask   <= mask_base | bus.node_rvalid;
         wr_ptr <= wr_ptr + q'(push);
         rd_ptr <= rd_ptr + q'(pop);
         count  <= count + (q+1)'(push) - (q+1)'(pop);
         if (dup || drop) error <= 1'b1;
         case (state)
            IDLE: if (go && legal) begin
               state           <= SEND_OP;
               bus.node_cvalid <= 1'b1;
               bus.node_cdata  <= w'(head_op);
            end
            SEND_OP: begin
               state          <= SEND_SIZE;
               bus.node_cdata <= w'(head_size);
            end
            SEND_SIZE: begin
               state           <= IDLE;
               bus.node_cvalid <= 1'b0;
               bus.node_cdata  <= '0;
               issued          <= issued + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/collective_scheduler.md
COLLECTIVE_SCHEDULER -- requirements
Module: collective_scheduler

Interface
REQ-001 Parameter x, default 4, number of nodes served.
REQ-002 Parameter w, default 128, controller data word width in bits.
REQ-003 Parameter d, default 5, node BRAM address width in bits.
REQ-004 Parameter q, default 2, log2 of the command FIFO depth.
REQ-005 clock  in  1  single clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid  in  1  host offers a command.
REQ-008 cmd_op  in  32  operation code: 0 = reduce-average, 1 = broadcast.
REQ-009 cmd_size  in  32  message size in bytes.
REQ-010 cmd_ready  out  1  FIFO can accept a command.
REQ-011 node_rvalid  in  x  per-node one-cycle ready pulse; bit v comes from node v's controllerovalid.
REQ-012 node_cvalid  out  1  broadcast valid to every node's controllerivalid.
REQ-013 node_cdata  out  w  broadcast data to every node's controllleridata.
REQ-014 busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
REQ-015 issued  out  16  count of commands broadcast; wraps at 2^16.
REQ-016 error  out  1  sticky error flag.

Function
REQ-017 Command FIFO depth 2^q; a command is pushed when cmd_valid && cmd_ready.
REQ-018 cmd_ready SHALL equal !full; a full FIFO ignores cmd_valid, and there is no bypass path.
REQ-019 A simultaneous push and pop on a non-empty FIFO SHALL keep the count unchanged; pointers wrap modulo 2^q.
REQ-020 The barrier mask (x bits) SHALL set bit v on the cycle after node_rvalid[v]=1.
REQ-021 A pulse on a bit already set in the mask SHALL set error; the mask is unchanged.
REQ-022 A command is legal iff op is 0 or 1, size != 0, size % (x*w/8) == 0, and size/(x*w/8) <= 2^d.
REQ-023 FSM states are IDLE, SEND_OP and SEND_SIZE.
REQ-024 IDLE, mask all-ones, FIFO non-empty, head legal: go to SEND_OP.
REQ-025 IDLE, mask all-ones, FIFO non-empty, head illegal: pop the head, set error, stay in IDLE, keep the mask.
REQ-026 IDLE with the mask incomplete or the FIFO empty: hold.
REQ-027 SEND_OP: node_cvalid=1, node_cdata = cmd_op zero-extended to w; always go to SEND_SIZE.
REQ-028 SEND_SIZE: node_cvalid=1, node_cdata = cmd_size zero-extended; pop the FIFO, clear the mask, increment issued, go to IDLE.
REQ-029 Pulses arriving during SEND_SIZE SHALL be recorded after the clear (set has priority over clear).
REQ-030 In IDLE, node_cvalid=0 and node_cdata=0.
REQ-031 Latency: with the FIFO non-empty, the last barrier pulse in cycle t SHALL give the op word in cycle t+2 and the size word in cycle t+3.
REQ-032 With the barrier complete and the FIFO empty, a push in cycle t SHALL give the op word in cycle t+2.
REQ-033 The FIFO SHALL keep accepting pushes during SEND_OP and SEND_SIZE.

Reset
REQ-034 reset=0 SHALL asynchronously set: state IDLE, FIFO empty, mask 0, node_cvalid 0, node_cdata 0, issued 0, error 0, busy 0, cmd_ready 1.
REQ-035 Reset asserted mid-broadcast SHALL abort the broadcast and discard all queued commands.
REQ-036 After release, only new node pulses can complete the barrier.
REQ-037 Outputs SHALL update only on posedge clock after reset deasserts.

Verification
REQ-038 Scenario: push (op=0, size=256); pulse all four nodes in cycle 10 -> op=0 valid in cycle 12, size=256 in cycle 13, issued=1, busy low in cycle 14.
REQ-039 Scenario: pulse nodes 0-2 only, then push a legal command -> no node_cvalid; pulse node 3 in cycle t -> op word in cycle t+2.
REQ-040 Scenario: push (op=2, size=64), then (op=1, size=128), then barrier -> first command dropped, error=1, op=1/size=128 broadcast, issued=1.
REQ-041 Scenario: push 5 commands back-to-back with no barrier -> cmd_ready low after the 4th; the 5th is not accepted; count stays 4.
REQ-042 Scenario: pulse node 1 twice before the barrier -> error=1, mask unchanged.
REQ-043 Scenario: assert reset during SEND_OP -> node_cvalid 0 immediately, issued 0, FIFO empty, cmd_ready 1.
